// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the branch sequencer: condition codes, NZCV bit
// positions and the sequencer state encoding.
package branch_sequencer_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FLAGS,
    ST_EVAL,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// Combinational condition-code evaluator: decides whether a branch with the
// given 4-bit condition is taken under the supplied NZCV flags.
module cond_eval
  import branch_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       take
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    take = 1'b0;
    case (cond)
      COND_EQ: take = z;
      COND_NE: take = !z;
      COND_CS: take = c;
      COND_CC: take = !c;
      COND_MI: take = n;
      COND_PL: take = !n;
      COND_VS: take = v;
      COND_VC: take = !v;
      COND_HI: take = c & !z;
      COND_LS: take = !c | z;
      COND_GE: take = (n == v);
      COND_LT: take = (n != v);
      COND_GT: take = !z & (n == v);
      COND_LE: take = z | (n != v);
      COND_AL: take = 1'b1;
      COND_NV: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: owns the NZCV flag register, waits out
// pending flag writes, evaluates the condition and drives PC/LR/flush.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flags_we,
  input  logic [3:0]            flags_in,
  input  logic                  flags_pending,
  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [3:0]            br_cond,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic                  br_link,
  input  logic [DATA_WIDTH-1:0] br_return_addr,
  output logic                  pc_load,
  output logic [DATA_WIDTH-1:0] pc_target,
  output logic                  lr_we,
  output logic [DATA_WIDTH-1:0] lr_data,
  output logic                  flush,
  output logic                  stall,
  output logic [3:0]            flags_out,
  output logic [CNT_WIDTH-1:0]  taken_count
);

  state_t                state_q, state_d;
  logic [3:0]            flags_q, flags_d;
  logic [3:0]            cond_q, cond_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  link_q, link_d;
  logic [DATA_WIDTH-1:0] ret_q, ret_d;
  logic                  pc_load_q, pc_load_d;
  logic [DATA_WIDTH-1:0] pc_target_q, pc_target_d;
  logic                  lr_we_q, lr_we_d;
  logic [DATA_WIDTH-1:0] lr_data_q, lr_data_d;
  logic [CNT_WIDTH-1:0]  taken_q, taken_d;
  logic [3:0]            fcnt_q, fcnt_d;
  logic [3:0]            eval_flags;
  logic                  take;

  // A flag write landing in the EVAL cycle itself is bypassed into the decision.
  assign eval_flags = flags_we ? flags_in : flags_q;

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (eval_flags),
    .take  (take)
  );

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_we ? flags_in : flags_q;
    cond_d      = cond_q;
    target_d    = target_q;
    link_d      = link_q;
    ret_d       = ret_q;
    pc_load_d   = 1'b0;
    pc_target_d = pc_target_q;
    lr_we_d     = 1'b0;
    lr_data_d   = lr_data_q;
    taken_d     = taken_q;
    fcnt_d      = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          cond_d   = br_cond;
          target_d = br_target;
          link_d   = br_link;
          ret_d    = br_return_addr;
          state_d  = flags_pending ? ST_WAIT_FLAGS : ST_EVAL;
        end
      end
      ST_WAIT_FLAGS: begin
        if (!flags_pending) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (take) begin
          pc_load_d   = 1'b1;
          pc_target_d = target_q;
          if (link_q) begin
            lr_we_d   = 1'b1;
            lr_data_d = ret_q;
          end
          taken_d = taken_q + 1'b1;
          fcnt_d  = 4'(FLUSH_CYCLES - 1);
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_IDLE;
        else fcnt_d = fcnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flags_q     <= '0;
      cond_q      <= '0;
      target_q    <= '0;
      link_q      <= 1'b0;
      ret_q       <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      lr_we_q     <= 1'b0;
      lr_data_q   <= '0;
      taken_q     <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      cond_q      <= cond_d;
      target_q    <= target_d;
      link_q      <= link_d;
      ret_q       <= ret_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      lr_we_q     <= lr_we_d;
      lr_data_q   <= lr_data_d;
      taken_q     <= taken_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign br_ready    = (state_q == ST_IDLE);
  assign stall       = (state_q != ST_IDLE);
  assign flush       = (state_q == ST_FLUSH);
  assign pc_load     = pc_load_q;
  assign pc_target   = pc_target_q;
  assign lr_we       = lr_we_q;
  assign lr_data     = lr_data_q;
  assign flags_out   = flags_q;
  assign taken_count = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer.
module tb_branch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic        flags_pending;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [31:0] br_target;
  logic        br_link;
  logic [31:0] br_return_addr;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        lr_we;
  logic [31:0] lr_data;
  logic        flush;
  logic        stall;
  logic [3:0]  flags_out;
  logic [15:0] taken_count;

  int checks = 0;
  int errors = 0;

  branch_sequencer #(
    .DATA_WIDTH   (32),
    .FLUSH_CYCLES (2),
    .CNT_WIDTH    (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .flags_we       (flags_we),
    .flags_in       (flags_in),
    .flags_pending  (flags_pending),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .br_target      (br_target),
    .br_link        (br_link),
    .br_return_addr (br_return_addr),
    .pc_load        (pc_load),
    .pc_target      (pc_target),
    .lr_we          (lr_we),
    .lr_data        (lr_data),
    .flush          (flush),
    .stall          (stall),
    .flags_out      (flags_out),
    .taken_count    (taken_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    flags_we = 1'b1;
    flags_in = f;
    tick();
    flags_we = 1'b0;
  endtask

  // Present a request for one cycle (IDLE assumed) and step past the handshake.
  task automatic request(input logic [3:0] c, input logic [31:0] t,
                         input logic l, input logic [31:0] ra);
    br_valid       = 1'b1;
    br_cond        = c;
    br_target      = t;
    br_link        = l;
    br_return_addr = ra;
    tick();
    br_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flags_we = 1'b0; flags_in = '0; flags_pending = 1'b0;
    br_valid = 1'b0; br_cond = '0; br_target = '0; br_link = 1'b0; br_return_addr = '0;
    tick(); tick();
    chk("rst_ready", br_ready, 1);
    chk("rst_flags", flags_out, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_lr_we", lr_we, 0);
    chk("rst_flush", flush, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_lr_data", lr_data, 0);
    chk("rst_count", taken_count, 0);
    reset = 1'b0;
    tick();

    // EQ taken with Z set
    set_flags(4'b0100);
    chk("t1_flags", flags_out, 4'b0100);
    request(4'h0, 32'h100, 1'b0, 32'h0);
    chk("t1_eval_stall", stall, 1);
    chk("t1_eval_ready", br_ready, 0);
    chk("t1_eval_pcload", pc_load, 0);
    tick();
    chk("t1_pcload", pc_load, 1);
    chk("t1_pctarget", pc_target, 32'h100);
    chk("t1_flush0", flush, 1);
    chk("t1_lrwe", lr_we, 0);
    chk("t1_count", taken_count, 1);
    tick();
    chk("t1_pcload_pulse", pc_load, 0);
    chk("t1_flush1", flush, 1);
    chk("t1_ready_busy", br_ready, 0);
    tick();
    chk("t1_flush_end", flush, 0);
    chk("t1_ready", br_ready, 1);
    chk("t1_stall_end", stall, 0);

    // EQ not taken with Z clear
    set_flags(4'b0000);
    request(4'h0, 32'h180, 1'b0, 32'h0);
    chk("t2_eval_stall", stall, 1);
    tick();
    chk("t2_pcload", pc_load, 0);
    chk("t2_flush", flush, 0);
    chk("t2_ready", br_ready, 1);
    chk("t2_count", taken_count, 1);

    // LT waits for pending flags, then sees N=1,V=0
    flags_pending = 1'b1;
    request(4'hB, 32'h200, 1'b0, 32'h0);
    chk("t3_wait_stall", stall, 1);
    chk("t3_wait_ready", br_ready, 0);
    tick();
    chk("t3_wait2", pc_load, 0);
    flags_we = 1'b1; flags_in = 4'b1000;
    tick();
    flags_we = 1'b0; flags_pending = 1'b0;
    chk("t3_flags", flags_out, 4'b1000);
    chk("t3_still_wait", stall, 1);
    tick();
    chk("t3_eval_pcload", pc_load, 0);
    tick();
    chk("t3_pcload", pc_load, 1);
    chk("t3_pctarget", pc_target, 32'h200);
    chk("t3_count", taken_count, 2);
    tick(); tick();
    chk("t3_ready", br_ready, 1);

    // LE with N=1,V=0,Z=0 taken
    request(4'hD, 32'h300, 1'b0, 32'h0);
    tick();
    chk("t4_le_pcload", pc_load, 1);
    chk("t4_le_target", pc_target, 32'h300);
    chk("t4_le_count", taken_count, 3);
    tick(); tick();
    // NV never taken
    request(4'hF, 32'h400, 1'b0, 32'h0);
    tick();
    chk("t4_nv_pcload", pc_load, 0);
    chk("t4_nv_count", taken_count, 3);
    chk("t4_nv_target", pc_target, 32'h300);
    // AL with flags 0000 taken
    set_flags(4'b0000);
    request(4'hE, 32'h500, 1'b0, 32'h0);
    tick();
    chk("t4_al_pcload", pc_load, 1);
    chk("t4_al_target", pc_target, 32'h500);
    chk("t4_al_count", taken_count, 4);
    tick(); tick();

    // EQ decided by a flag write bypassed in the EVAL cycle
    request(4'h0, 32'h600, 1'b0, 32'h0);
    flags_we = 1'b1; flags_in = 4'b0100;
    tick();
    flags_we = 1'b0;
    chk("t5_bypass_pcload", pc_load, 1);
    chk("t5_bypass_count", taken_count, 5);
    tick(); tick();

    // Branch-with-link; second request held during flush
    request(4'hE, 32'h700, 1'b1, 32'h44);
    tick();
    chk("t6_pcload", pc_load, 1);
    chk("t6_lrwe", lr_we, 1);
    chk("t6_lrdata", lr_data, 32'h44);
    chk("t6_count", taken_count, 6);
    br_valid = 1'b1; br_cond = 4'hE; br_target = 32'h800; br_link = 1'b0; br_return_addr = 32'h88;
    chk("t6_ready_flush0", br_ready, 0);
    tick();
    chk("t6_ready_flush1", br_ready, 0);
    chk("t6_lrwe_pulse", lr_we, 0);
    tick();
    chk("t6_ready_idle", br_ready, 1);
    tick();
    br_valid = 1'b0;
    chk("t6_second_eval", stall, 1);
    tick();
    chk("t6_second_pcload", pc_load, 1);
    chk("t6_second_target", pc_target, 32'h800);
    chk("t6_second_lrwe", lr_we, 0);
    chk("t6_second_lrdata", lr_data, 32'h44);
    chk("t6_second_count", taken_count, 7);
    tick(); tick();

    // Reset while in WAIT_FLAGS aborts the branch
    flags_pending = 1'b1;
    request(4'hE, 32'h900, 1'b0, 32'h0);
    chk("t7_wait", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; flags_pending = 1'b0;
    chk("t7_ready", br_ready, 1);
    chk("t7_flags", flags_out, 0);
    chk("t7_stall", stall, 0);
    chk("t7_count", taken_count, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t7_no_pcload", pc_load, 0);
      chk("t7_no_flush", flush, 0);
      tick();
    end
    chk("t7_target", pc_target, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Owns the architectural NZCV flag register and sequences conditional branches for the core's control unit.
- Accepts one branch request at a time.
- Waits out any in-flight flag-setting instruction.
- Evaluates the 4-bit condition code against the flags.
- On taken: loads the PC, optionally writes the link register, then drives a fixed-length pipeline flush.
- Sits between decode (request side) and the PC/regfile/pipeline-control logic.

Parameters:
DATA_WIDTH, 32, width of branch target, return address and PC/LR data
FLUSH_CYCLES, 2, cycles flush is held after a taken branch (legal 1..15)
CNT_WIDTH, 16, width of taken-branch statistics counter

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
flags_we  in  1  ALU writes flags this cycle
flags_in  in  4  new flags {N,Z,C,V}
flags_pending  in  1  flag-setting instruction in flight, not yet written
br_valid  in  1  branch request valid
br_ready  out  1  sequencer can accept a request
br_cond  in  4  condition code
br_target  in  DATA_WIDTH  branch destination
br_link  in  1  branch-with-link
br_return_addr  in  DATA_WIDTH  value for LR on link
pc_load  out  1  one-cycle pulse: PC <= pc_target
pc_target  out  DATA_WIDTH  registered target
lr_we  out  1  one-cycle pulse, coincident with pc_load when linking
lr_data  out  DATA_WIDTH  registered return address
flush  out  1  kill younger pipeline stages
stall  out  1  hold fetch/decode
flags_out  out  4  current architectural flags {N,Z,C,V}
taken_count  out  CNT_WIDTH  number of taken branches since reset

Behaviour:
- Reset (synchronous, active-high): state IDLE; flags_out=0000; pc_load, lr_we, flush, stall = 0; pc_target = lr_data = 0; taken_count = 0.
- Reset mid-operation aborts any branch with no pc_load.
- Flag register: updated on every cycle with flags_we=1, in any state; flags_out is the registered value.
- br_ready = (state==IDLE). A handshake is br_valid & br_ready; on handshake, latch cond, target, link and return_addr.
- States: IDLE, WAIT_FLAGS, EVAL, FLUSH.
- IDLE, on handshake: go to WAIT_FLAGS if flags_pending=1, else EVAL. No handshake: stay in IDLE.
- WAIT_FLAGS: stay while flags_pending=1; go to EVAL on the cycle flags_pending=0.
- EVAL lasts one cycle. Effective flags = flags_in if flags_we=1 that cycle (bypass), else flags_out.
  - Taken: pc_load=1 and pc_target = latched target on the next cycle; lr_we=1 with the same timing if link; taken_count += 1 (wraps at 2^CNT_WIDTH); go to FLUSH.
  - Not taken: return to IDLE with no pulses.
- FLUSH: flush=1 for exactly FLUSH_CYCLES cycles (down-counter), then IDLE.
- stall=1 whenever state != IDLE.
- Latency, no pending flags: handshake cycle T, EVAL at T+1, pc_load at T+2, flush at T+2..T+1+FLUSH_CYCLES, br_ready high at T+2+FLUSH_CYCLES.
- Condition codes (combinational evaluator):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z & (N==V)
  - D LE: Z | (N!=V)
  - E AL: 1
  - F NV: 0
- br_valid while busy is ignored; the requester holds it until br_ready.
- flags_we together with handshake in IDLE: the flags register updates and the EVAL cycle uses the updated register.

Decomposition:
- Shared package: condition-code constants COND_EQ..COND_NV, flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, and the state encoding.
- One sub-module: cond_eval (combinational, 4-bit cond + 4 flags -> take), instantiated once for EVAL.

Test Plan:
- Reset, then flags_we with flags_in=0100 (Z), request cond=0 target=0x100 -> pc_load at T+2 with pc_target=0x100, flush for 2 cycles, taken_count=1.
- Flags=0000, request cond=0 -> no pc_load, no flush, br_ready high at T+2, taken_count unchanged.
- flags_pending=1 for 3 cycles at request, flags_we with flags_in=1000 on the third cycle, cond=B (LT) -> EVAL after pending drops, branch taken.
- cond=D with Z=0, N=1, V=0 -> taken; cond=F -> never taken; cond=E with flags 0000 -> taken.
- br_link=1, br_return_addr=0x44 -> lr_we and pc_load pulse in the same cycle with lr_data=0x44; a second br_valid during FLUSH is not accepted until br_ready.
- Reset asserted in WAIT_FLAGS -> next cycle IDLE, flags_out=0000, no pc_load ever issued for the aborted branch.
